// File: rtl/prr_st_valid_sched.sv
// -----------------------------------------------------------------------------
// prr_st_valid_sched
//
// Store-stream valid scheduler for one PRR-to-GLB channel. Software programs
// a loop nest (dimension, per-level extent and cycle stride) through the CGRA
// config bus. After a start pulse a free-running, stall-aware cycle counter is
// compared against the current loop-nest target; every match produces a
// one-cycle valid strobe and advances the nest odometer-style (level 0
// fastest). A counter that overtakes its target flags a sticky error.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   cfg_wr_en/addr/data     config write port (accepted in IDLE/DONE only)
//   cfg_rd_en/addr          config read request
//   cfg_rd_data             combinational readback, 0 if disabled/unmapped
//   start                   launches the schedule from IDLE or DONE
//   stall                   freezes counter, iterators and state
//   flush                   synchronous abort to IDLE (wins over start/stall)
//   valid_o                 registered valid strobe toward io1 PRR-to-GLB
//   busy_o                  high while running
//   done_o                  high once the schedule has ended
//   err_o                   sticky: a target was missed
//
// Register map (address bits [4:0]):
//   0        CTRL, bits[3:0] = dim
//   1 + 2i   extent[i]   (0 behaves as 1)
//   2 + 2i   cycle_stride[i]
// -----------------------------------------------------------------------------
module prr_st_valid_sched #(
    parameter int LOOP_LEVEL          = 8,
    parameter int CNT_WIDTH           = 32,
    parameter int CGRA_CFG_ADDR_WIDTH = 32,
    parameter int CGRA_CFG_DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           cfg_wr_en,
    input  logic [CGRA_CFG_ADDR_WIDTH-1:0] cfg_wr_addr,
    input  logic [CGRA_CFG_DATA_WIDTH-1:0] cfg_wr_data,
    input  logic                           cfg_rd_en,
    input  logic [CGRA_CFG_ADDR_WIDTH-1:0] cfg_rd_addr,
    output logic [CGRA_CFG_DATA_WIDTH-1:0] cfg_rd_data,
    input  logic                           start,
    input  logic                           stall,
    input  logic                           flush,
    output logic                           valid_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                               state_reg, state_next;
    logic [3:0]                           dim_reg;
    logic [CNT_WIDTH-1:0]                 cnt_reg;
    logic                                 valid_reg, valid_next;
    logic                                 err_reg, err_next;

    logic                                 cnt_clr, cnt_inc, it_clr, advance;
    logic                                 dim_ok, all_wrap, cfg_wr_ok, carry;
    logic [4:0]                           wr_idx, rd_idx;
    logic [LOOP_LEVEL-1:0]                active, wrap, inc;
    logic [CNT_WIDTH-1:0]                 target;
    logic [LOOP_LEVEL-1:0][CNT_WIDTH-1:0] cur_all, extent_all, stride_all;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{cfg_wr_addr[CGRA_CFG_ADDR_WIDTH-1:5],
                                cfg_rd_addr[CGRA_CFG_ADDR_WIDTH-1:5]};

    assign wr_idx    = cfg_wr_addr[4:0];
    assign rd_idx    = cfg_rd_addr[4:0];
    assign cfg_wr_ok = cfg_wr_en && (state_reg != ST_RUN);
    assign dim_ok    = (dim_reg != 4'd0) && (int'(dim_reg) <= LOOP_LEVEL);

    // ------------------------------------------------------------------
    // Per-level configuration, iterator and running partial target.
    // cur_reg tracks it_reg * stride incrementally so no multiplier is needed.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < LOOP_LEVEL; gi++) begin : g_lvl
        logic [CNT_WIDTH-1:0] extent_reg, stride_reg, it_reg, cur_reg;

        assign active[gi] = (int'(dim_reg) > gi);
        // extent 0 and 1 both mean a single iteration, so the level always wraps
        assign wrap[gi]   = (extent_reg <= CNT_ONE) ? 1'b1
                                                    : (it_reg == (extent_reg - CNT_ONE));

        assign cur_all[gi]    = cur_reg;
        assign extent_all[gi] = extent_reg;
        assign stride_all[gi] = stride_reg;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                extent_reg <= '0;
                stride_reg <= '0;
            end else if (cfg_wr_ok) begin
                if (wr_idx == 5'(1 + 2 * gi)) extent_reg <= CNT_WIDTH'(cfg_wr_data);
                if (wr_idx == 5'(2 + 2 * gi)) stride_reg <= CNT_WIDTH'(cfg_wr_data);
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                it_reg  <= '0;
                cur_reg <= '0;
            end else if (it_clr) begin
                it_reg  <= '0;
                cur_reg <= '0;
            end else if (inc[gi]) begin
                if (wrap[gi]) begin
                    it_reg  <= '0;
                    cur_reg <= '0;
                end else begin
                    it_reg  <= it_reg + CNT_ONE;
                    cur_reg <= cur_reg + stride_reg;
                end
            end
        end
    end

    // Odometer carry: a level steps only when every faster level wraps.
    always_comb begin
        inc   = '0;
        carry = advance;
        for (int i = 0; i < LOOP_LEVEL; i++) begin
            inc[i] = carry & active[i];
            carry  = carry & wrap[i];
        end
    end

    // Last match of the nest: every active level wraps on this advance.
    assign all_wrap = &(wrap | ~active);

    // Target = sum of active partial targets, truncated to CNT_WIDTH.
    always_comb begin
        target = '0;
        for (int i = 0; i < LOOP_LEVEL; i++) begin
            if (active[i]) target = target + cur_all[i];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        valid_next = 1'b0;
        err_next   = err_reg;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        it_clr     = 1'b0;
        advance    = 1'b0;
        if (flush) begin
            state_next = ST_IDLE;
            err_next   = 1'b0;
            it_clr     = 1'b1;
            cnt_clr    = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        it_clr     = 1'b1;
                        cnt_clr    = 1'b1;
                        err_next   = 1'b0;
                        // an illegal dimension ends immediately with no valids
                        state_next = dim_ok ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        cnt_inc = 1'b1;
                        if (cnt_reg == target) begin
                            valid_next = 1'b1;
                            advance    = 1'b1;
                            if (all_wrap) state_next = ST_DONE;
                        end else if (cnt_reg > target) begin
                            err_next   = 1'b1;
                            state_next = ST_DONE;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
            dim_reg <= 4'd0;
        end else begin
            if (cnt_clr)      cnt_reg <= '0;
            else if (cnt_inc) cnt_reg <= cnt_reg + CNT_ONE;
            if (cfg_wr_ok && (wr_idx == 5'd0)) dim_reg <= cfg_wr_data[3:0];
        end
    end

    // ------------------------------------------------------------------
    // Config readback
    // ------------------------------------------------------------------
    always_comb begin
        cfg_rd_data = '0;
        if (cfg_rd_en) begin
            if (rd_idx == 5'd0) cfg_rd_data = CGRA_CFG_DATA_WIDTH'(dim_reg);
            for (int i = 0; i < LOOP_LEVEL; i++) begin
                if (rd_idx == 5'(1 + 2 * i)) cfg_rd_data = CGRA_CFG_DATA_WIDTH'(extent_all[i]);
                if (rd_idx == 5'(2 + 2 * i)) cfg_rd_data = CGRA_CFG_DATA_WIDTH'(stride_all[i]);
            end
        end
    end

    assign valid_o = valid_reg;
    assign busy_o  = (state_reg == ST_RUN);
    assign done_o  = (state_reg == ST_DONE);
    assign err_o   = err_reg;

endmodule

// File: tb/tb_prr_st_valid_sched.sv
// -----------------------------------------------------------------------------
// tb_prr_st_valid_sched
//
// Directed bench for prr_st_valid_sched. Each schedule run launches start in
// cycle 0 and records valid_o/busy_o/done_o/err_o per cycle into bit masks
// (bit k = cycle k), which are compared against hand-computed masks.
// -----------------------------------------------------------------------------
module tb_prr_st_valid_sched;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_wr_en = 1'b0;
    logic [31:0] cfg_wr_addr = '0;
    logic [31:0] cfg_wr_data = '0;
    logic        cfg_rd_en = 1'b0;
    logic [31:0] cfg_rd_addr = '0;
    logic [31:0] cfg_rd_data;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        valid_o, busy_o, done_o, err_o;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    always #5 clk = ~clk;

    prr_st_valid_sched #(
        .LOOP_LEVEL          (8),
        .CNT_WIDTH           (32),
        .CGRA_CFG_ADDR_WIDTH (32),
        .CGRA_CFG_DATA_WIDTH (32)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_wr_en   (cfg_wr_en),
        .cfg_wr_addr (cfg_wr_addr),
        .cfg_wr_data (cfg_wr_data),
        .cfg_rd_en   (cfg_rd_en),
        .cfg_rd_addr (cfg_rd_addr),
        .cfg_rd_data (cfg_rd_data),
        .start       (start),
        .stall       (stall),
        .flush       (flush),
        .valid_o     (valid_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int k = lo; k <= hi; k++) m[k] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] bit1(input int k);
        logic [63:0] m;
        m = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = addr;
        cfg_wr_data = data;
        step();
        cfg_wr_en   = 1'b0;
    endtask

    task automatic cfg_read(input logic [31:0] addr, output logic [31:0] data);
        cfg_rd_en   = 1'b1;
        cfg_rd_addr = addr;
        #1;
        data        = cfg_rd_data;
        cfg_rd_en   = 1'b0;
    endtask

    // start high in cycle 0; stall high in cycles st_lo..st_hi; flush in fl_at
    task automatic run(input int ncyc, input int st_lo, input int st_hi, input int fl_at,
                       output logic [63:0] vm, output logic [63:0] bm,
                       output logic [63:0] dm, output logic [63:0] em);
        vm = '0; bm = '0; dm = '0; em = '0;
        start = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            stall = (k >= st_lo) && (k <= st_hi);
            flush = (k == fl_at);
            @(negedge clk);
            vm[k] = valid_o;
            bm[k] = busy_o;
            dm[k] = done_o;
            em[k] = err_o;
        end
        stall = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] vm, bm, dm, em;
        logic [31:0] rd;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", {60'b0, valid_o, busy_o, done_o, err_o}, 64'h0);
        reset_n = 1'b1;
        step();
        check("rst_outs_rel", {60'b0, valid_o, busy_o, done_o, err_o}, 64'h0);
        cfg_read(32'd2, rd);
        check("rst_cfg", {32'b0, rd}, 64'h0);

        // ---- 1D: extent 4, stride 2 ----
        cfg_write(32'd0, 32'd1);
        cfg_write(32'd1, 32'd4);
        cfg_write(32'd2, 32'd2);
        run(12, 0, -1, 0, vm, bm, dm, em);
        check("1d_valid", vm, bit1(2) | bit1(4) | bit1(6) | bit1(8));
        check("1d_busy",  bm, rng(1, 7));
        check("1d_done",  dm, rng(8, 12));
        check("1d_err",   em, 64'h0);

        // ---- 1D with stall in cycles 3-5 ----
        run(14, 3, 5, 0, vm, bm, dm, em);
        check("stl_valid", vm, bit1(2) | bit1(7) | bit1(9) | bit1(11));
        check("stl_busy",  bm, rng(1, 10));
        check("stl_done",  dm, rng(11, 14));

        // ---- error: extent 3, stride 0 ----
        cfg_write(32'd1, 32'd3);
        cfg_write(32'd2, 32'd0);
        run(8, 0, -1, 0, vm, bm, dm, em);
        check("err_valid", vm, bit1(2));
        check("err_busy",  bm, rng(1, 2));
        check("err_done",  dm, rng(3, 8));
        check("err_err",   em, rng(3, 8));

        // ---- 2D: extent {2,3}, stride {1,10} ----
        cfg_write(32'd0, 32'd2);
        cfg_write(32'd1, 32'd2);
        cfg_write(32'd2, 32'd1);
        cfg_write(32'd3, 32'd3);
        cfg_write(32'd4, 32'd10);
        run(30, 0, -1, 0, vm, bm, dm, em);
        check("2d_valid", vm, bit1(2) | bit1(3) | bit1(12) | bit1(13) | bit1(22) | bit1(23));
        check("2d_nvalid", 64'($countones(vm)), 64'd6);
        check("2d_busy",  bm, rng(1, 22));
        check("2d_done",  dm, rng(23, 30));
        check("2d_err",   em, 64'h0);

        // ---- 2D with flush in cycle 5 ----
        run(10, 0, -1, 5, vm, bm, dm, em);
        check("fl_valid", vm, bit1(2) | bit1(3));
        check("fl_busy",  bm, rng(1, 5));
        check("fl_done",  dm, 64'h0);
        check("fl_err",   em, 64'h0);
        cfg_read(32'd0, rd);
        check("fl_ctrl", {32'b0, rd}, 64'd2);
        cfg_read(32'd1, rd);
        check("fl_ext0", {32'b0, rd}, 64'd2);
        cfg_read(32'd4, rd);
        check("fl_str1", {32'b0, rd}, 64'd10);

        // ---- config write during RUN is dropped ----
        cfg_write(32'd0, 32'd1);
        cfg_write(32'd1, 32'd4);
        cfg_write(32'd2, 32'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        check("run_busy", {63'b0, busy_o}, 64'd1);
        cfg_write(32'd0, 32'd2);
        cfg_read(32'd0, rd);
        check("run_ctrl_drop", {32'b0, rd}, 64'd1);
        repeat (10) step();
        check("run_done", {63'b0, done_o}, 64'd1);

        // ---- unmapped address and disabled read ----
        cfg_write(32'h1F, 32'hDEAD);
        cfg_read(32'h1F, rd);
        check("unmap_1f", {32'b0, rd}, 64'h0);
        cfg_read(32'd17, rd);
        check("unmap_17", {32'b0, rd}, 64'h0);
        cfg_rd_en   = 1'b0;
        cfg_rd_addr = 32'd1;
        #1;
        check("rd_en_off", {32'b0, cfg_rd_data}, 64'h0);
        cfg_read(32'd1, rd);
        check("rd_ext0", {32'b0, rd}, 64'd4);

        // ---- illegal dim goes straight to DONE ----
        cfg_write(32'd0, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("dim0", {60'b0, valid_o, busy_o, done_o, err_o}, 64'h2);
        cfg_write(32'd0, 32'd9);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("dim9", {60'b0, valid_o, busy_o, done_o, err_o}, 64'h2);

        // ---- asynchronous reset in RUN ----
        cfg_write(32'd0, 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("pre_rst_busy", {63'b0, busy_o}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_outs", {60'b0, valid_o, busy_o, done_o, err_o}, 64'h0);
        cfg_read(32'd1, rd);
        check("arst_ext0", {32'b0, rd}, 64'h0);
        cfg_read(32'd0, rd);
        check("arst_ctrl", {32'b0, rd}, 64'h0);
        step();
        reset_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
